bit_column_scheduler: RTL

- Upstream control stage for the 16-wide vertical bit-serial MAC unit.
- Accepts one signed weight vector (VEC_LENGTH x DATA_WIDTH) per handshake and walks its bit columns MSB to LSB, one column per issue.
- Per column and per 8-lane group, selects at most 4 lanes for the MAC's 9:1 activation muxes: either the 1-bit lanes directly, or the 0-bit lanes, which the MAC subtracts from the group sum_act.
- Drives act_sel, is_skip_zero, is_msb, column_idx and the MAC enable.

---
 rtl/bit_column_scheduler_if.sv | 30 +++
 rtl/bit_column_scheduler.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bit_column_scheduler_if.sv
// Weight-capture and column-issue bus between the weight source, the bit-column
// scheduler and the bit-serial MAC.
interface bit_column_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int SEL_WIDTH  = $clog2(VEC_LENGTH),
  parameter int COL_WIDTH  = $clog2(DATA_WIDTH)
);
  logic signed [DATA_WIDTH-1:0] w_in [VEC_LENGTH];
  logic                         w_valid;
  logic                         w_ready;
  logic                         stall;
  logic [SEL_WIDTH-1:0]         act_sel [VEC_LENGTH/2];
  logic [VEC_LENGTH/8-1:0]      is_skip_zero;
  logic                         is_msb;
  logic [COL_WIDTH-1:0]         column_idx;
  logic                         col_valid;
  logic                         mac_en;
  logic                         last_col;

  modport master (
    output w_in, w_valid, stall,
    input  w_ready, act_sel, is_skip_zero, is_msb, column_idx, col_valid, mac_en, last_col
  );

  modport slave (
    input  w_in, w_valid, stall,
    output w_ready, act_sel, is_skip_zero, is_msb, column_idx, col_valid, mac_en, last_col
  );
endinterface

// File: rtl/bit_column_scheduler.sv
// Walks the bit columns of a signed weight vector MSB to LSB and issues per-group lane selects
// to the bit-serial MAC. Define BIT_COLUMN_SCHED_STATS_EN to add the inv_col_cnt/vec_cnt counters.
module bit_column_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int SEL_WIDTH  = $clog2(VEC_LENGTH),
  parameter int COL_WIDTH  = $clog2(DATA_WIDTH),
  parameter int ZERO_SEL   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  bit_column_scheduler_if.slave bus
`ifdef BIT_COLUMN_SCHED_STATS_EN
  ,
  output logic [31:0]           inv_col_cnt,
  output logic [31:0]           vec_cnt
`endif
);

  localparam int                   NGRP    = VEC_LENGTH / 8;
  localparam logic [COL_WIDTH-1:0] CNT_TOP = COL_WIDTH'(DATA_WIDTH - 1);
  localparam logic [SEL_WIDTH-1:0] ZSEL    = SEL_WIDTH'(ZERO_SEL);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       state, state_nxt;
  logic signed [DATA_WIDTH-1:0] w_p0 [VEC_LENGTH];
  logic [COL_WIDTH-1:0]         cnt_p0;
  logic [SEL_WIDTH-1:0]         act_sel_p1 [VEC_LENGTH/2];
  logic [NGRP-1:0]              skip_p1;
  logic                         is_msb_p1, last_col_p1, vld_p1;
  logic [COL_WIDTH-1:0]         column_idx_p1;
  logic                         can_issue, issue, capture, w_ready;
  logic [4*SEL_WIDTH-1:0]       sel_col [NGRP];
  logic [NGRP-1:0]              skip_col;

  // Few set bits: send the 1-lanes; otherwise send the (at most 3) 0-lanes for subtraction.
  function automatic logic keep_ones(input logic [7:0] b);
    return $countones(b) <= 4;
  endfunction

  function automatic logic [4*SEL_WIDTH-1:0] pick_lanes(input logic [7:0] b);
    logic [4*SEL_WIDTH-1:0] sel;
    logic                   tgt;
    int                     n;
    sel = {4{ZSEL}};
    tgt = keep_ones(b);
    n   = 0;
    for (int k = 0; k < 8; k++) begin
      if (b[k] == tgt && n < 4) begin
        sel[n*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(k);
        n++;
      end
    end
    return sel;
  endfunction

  // p0: captured weights and column counter -> per-group column selection
  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    logic [7:0] bits;
    for (genvar k = 0; k < 8; k++) begin : g_bit
      assign bits[k] = w_p0[8*g+k][cnt_p0];
    end
    assign sel_col[g]  = pick_lanes(bits);
    assign skip_col[g] = keep_ones(bits);
  end

  assign can_issue = ~vld_p1 | ~bus.stall;
  assign issue     = (state == RUN) & can_issue;
  assign w_ready   = (state == IDLE) | ((state == RUN) & (cnt_p0 == '0) & can_issue);
  assign capture   = bus.w_valid & w_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.w_valid) state_nxt = RUN;
      RUN:     if (issue && cnt_p0 == '0 && !capture) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // p1: registered column controls presented to the MAC
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < VEC_LENGTH; i++) w_p0[i] <= '0;
      cnt_p0        <= CNT_TOP;
      vld_p1        <= 1'b0;
      is_msb_p1     <= 1'b0;
      last_col_p1   <= 1'b0;
      column_idx_p1 <= '0;
      for (int j = 0; j < VEC_LENGTH/2; j++) act_sel_p1[j] <= ZSEL;
      skip_p1       <= '1;
    end else begin
      if (capture) begin
        for (int i = 0; i < VEC_LENGTH; i++) w_p0[i] <= bus.w_in[i];
        cnt_p0 <= CNT_TOP;
      end else if (issue && cnt_p0 != '0) begin
        cnt_p0 <= cnt_p0 - 1'b1;
      end
      if (issue) begin
        for (int g = 0; g < NGRP; g++)
          for (int j = 0; j < 4; j++)
            act_sel_p1[4*g+j] <= sel_col[g][j*SEL_WIDTH +: SEL_WIDTH];
        skip_p1       <= skip_col;
        is_msb_p1     <= (cnt_p0 == CNT_TOP);
        last_col_p1   <= (cnt_p0 == '0);
        column_idx_p1 <= cnt_p0;
        vld_p1        <= 1'b1;
      end else if (can_issue) begin
        vld_p1 <= 1'b0;
      end
    end
  end

`ifdef BIT_COLUMN_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      inv_col_cnt <= '0;
      vec_cnt     <= '0;
    end else begin
      if (issue && !(&skip_col) && inv_col_cnt != '1) inv_col_cnt <= inv_col_cnt + 1'b1;
      if (capture && vec_cnt != '1)                    vec_cnt     <= vec_cnt + 1'b1;
    end
  end
`endif

  assign bus.w_ready      = w_ready;
  assign bus.act_sel      = act_sel_p1;
  assign bus.is_skip_zero = skip_p1;
  assign bus.is_msb       = is_msb_p1;
  assign bus.column_idx   = column_idx_p1;
  assign bus.col_valid    = vld_p1;
  assign bus.last_col     = last_col_p1;
  assign bus.mac_en       = vld_p1 & ~bus.stall;

endmodule
